// File: rtl/blur_pkg.sv
// Shared types and constants for the blurring filter frame sequencer.
//   state_t       : frame-tracking FSM states
//   pixel_t       : 12-bit pixel word carried by the filter datapath
//   PIXEL_COUNT_W : width of the per-frame beat counter
package blur_pkg;

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    IN_FRAME = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  typedef logic [11:0] pixel_t;

  localparam int PIXEL_COUNT_W = 32;

endpackage

// File: rtl/blur_frame_sequencer_if.sv
// Snooped streaming handshake of the blurring filter.
//   in_*  : filter input side (valid/ready/startofpacket/endofpacket)
//   out_* : filter output side (valid/ready/startofpacket/endofpacket)
// master drives the handshake (the stream environment), slave observes it
// (the sequencer only listens, it never drives these wires).
interface blur_frame_sequencer_if;
  logic in_valid;
  logic in_ready;
  logic in_sop;
  logic in_eop;
  logic out_valid;
  logic out_ready;
  logic out_sop;
  logic out_eop;

  modport master (
    output in_valid, in_ready, in_sop, in_eop,
    output out_valid, out_ready, out_sop, out_eop
  );

  modport slave (
    input in_valid, in_ready, in_sop, in_eop,
    input out_valid, out_ready, out_sop, out_eop
  );
endinterface

// File: rtl/blur_flag_debouncer.sv
// Debounces the requested kernel size across frame boundaries.
//   clk, reset_n : clock, synchronous active-low reset
//   update       : one cycle per completed input frame (input EOP beat)
//   req          : requested kernel size sampled on update
//   candidate    : value currently being qualified
//   stable_ok    : candidate has held for at least STABLE_FRAMES frames
module blur_flag_debouncer #(
  parameter int STABLE_FRAMES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic update,
  input  logic req,
  output logic candidate,
  output logic stable_ok
);

  localparam int SW = $clog2(STABLE_FRAMES + 1);

  logic [SW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      candidate  <= 1'b0;
      stable_cnt <= '0;
    end else if (update) begin
      if (req == candidate) begin
        if (stable_cnt < SW'(STABLE_FRAMES))
          stable_cnt <= stable_cnt + SW'(1);
      end else begin
        candidate  <= req;
        stable_cnt <= SW'(1);
      end
    end
  end

  assign stable_ok = (stable_cnt >= SW'(STABLE_FRAMES));

endmodule

// File: rtl/blur_frame_sequencer.sv
// Frame-level controller for the blurring filter streaming datapath.
// Tracks frame boundaries on the snooped filter handshake, applies kernel
// size and bypass only between frames, counts pixels/frames and flags
// malformed frames and drain stalls.
//   clk, reset_n          : clock, synchronous active-low reset
//   bus                   : snooped filter input/output handshake (slave)
//   req_freq_flag         : requested kernel size (debounced over frames)
//   req_bypass            : requested bypass
//   freq_flag, bypass     : applied configuration to the filter
//   frame_active          : high in IN_FRAME and DRAIN
//   pixel_count           : input beats accepted in the current frame
//   frame_count           : completed frames (wraps)
//   err_len/sop/timeout   : one-cycle error pulses
//
// state    | meaning
// WAIT_SOP | idle between frames, waiting for an input SOP beat
// IN_FRAME | counting input beats until input EOP
// DRAIN    | input done, waiting for output EOP or drain timeout
module blur_frame_sequencer
  import blur_pkg::*;
#(
  parameter int IMAGE_WIDTH   = 320,
  parameter int IMAGE_HEIGHT  = 240,
  parameter int STABLE_FRAMES = 3,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  blur_frame_sequencer_if.slave    bus,
  input  logic                     req_freq_flag,
  input  logic                     req_bypass,
  output logic                     freq_flag,
  output logic                     bypass,
  output logic                     frame_active,
  output logic [PIXEL_COUNT_W-1:0] pixel_count,
  output logic [15:0]              frame_count,
  output logic                     err_len,
  output logic                     err_sop,
  output logic                     err_timeout
);

  localparam logic [PIXEL_COUNT_W-1:0] FRAME_PIXELS =
    PIXEL_COUNT_W'(IMAGE_WIDTH * IMAGE_HEIGHT);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  state_t                   state, state_d;
  logic [TW-1:0]            drain_timer, timer_d;
  logic [PIXEL_COUNT_W-1:0] pixel_d, final_count;
  logic [15:0]              frame_d;
  logic                     freq_d, bypass_d;
  logic                     err_len_d, err_sop_d, err_to_d;
  logic                     in_beat, out_beat, commit, dbn_update;
  logic                     candidate, stable_ok;
  logic                     unused_out_sop;

  // Output-side SOP is not monitored.
  assign unused_out_sop = bus.out_sop;

  blur_flag_debouncer #(
    .STABLE_FRAMES(STABLE_FRAMES)
  ) u_debouncer (
    .clk      (clk),
    .reset_n  (reset_n),
    .update   (dbn_update),
    .req      (req_freq_flag),
    .candidate(candidate),
    .stable_ok(stable_ok)
  );

  always_comb begin
    in_beat     = bus.in_valid && bus.in_ready;
    out_beat    = bus.out_valid && bus.out_ready;
    final_count = pixel_count + PIXEL_COUNT_W'(1);
    state_d     = state;
    timer_d     = drain_timer;
    pixel_d     = pixel_count;
    frame_d     = frame_count;
    freq_d      = freq_flag;
    bypass_d    = bypass;
    err_len_d   = 1'b0;
    err_sop_d   = 1'b0;
    err_to_d    = 1'b0;
    dbn_update  = 1'b0;
    commit      = 1'b0;

    case (state)
      WAIT_SOP: begin
        if (in_beat && bus.in_sop) begin
          pixel_d = PIXEL_COUNT_W'(1);
          state_d = IN_FRAME;
        end
      end
      IN_FRAME: begin
        if (in_beat) begin
          // EOP wins over a coincident SOP.
          if (bus.in_eop) begin
            pixel_d    = final_count;
            err_len_d  = (final_count != FRAME_PIXELS);
            dbn_update = 1'b1;
            timer_d    = '0;
            state_d    = DRAIN;
          end else if (bus.in_sop) begin
            err_sop_d = 1'b1;
            pixel_d   = PIXEL_COUNT_W'(1);
          end else begin
            pixel_d = final_count;
          end
        end
      end
      DRAIN: begin
        timer_d = drain_timer + TW'(1);
        if (out_beat && bus.out_eop) begin
          frame_d = frame_count + 16'd1;
          commit  = 1'b1;
          state_d = WAIT_SOP;
        end else if (drain_timer == TW'(DRAIN_TIMEOUT - 1)) begin
          // A stalled drain still releases the pending configuration.
          err_to_d = 1'b1;
          commit   = 1'b1;
          state_d  = WAIT_SOP;
        end
      end
      default: state_d = WAIT_SOP;
    endcase

    if (commit) begin
      bypass_d = req_bypass;
      if (stable_ok)
        freq_d = candidate;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= WAIT_SOP;
      drain_timer  <= '0;
      pixel_count  <= '0;
      frame_count  <= '0;
      freq_flag    <= 1'b0;
      bypass       <= 1'b0;
      frame_active <= 1'b0;
      err_len      <= 1'b0;
      err_sop      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_d;
      drain_timer  <= timer_d;
      pixel_count  <= pixel_d;
      frame_count  <= frame_d;
      freq_flag    <= freq_d;
      bypass       <= bypass_d;
      frame_active <= (state_d != WAIT_SOP);
      err_len      <= err_len_d;
      err_sop      <= err_sop_d;
      err_timeout  <= err_to_d;
    end
  end

endmodule

// File: tb/tb_blur_frame_sequencer.sv
// Directed bench for blur_frame_sequencer with a 9x7 frame, STABLE_FRAMES=3
// and DRAIN_TIMEOUT=16.
module tb_blur_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_freq_flag = 1'b0;
  logic        req_bypass = 1'b0;
  logic        freq_flag, bypass, frame_active;
  logic [31:0] pixel_count;
  logic [15:0] frame_count;
  logic        err_len, err_sop, err_timeout;

  int checks = 0;
  int errors = 0;

  blur_frame_sequencer_if bus ();

  blur_frame_sequencer #(
    .IMAGE_WIDTH  (9),
    .IMAGE_HEIGHT (7),
    .STABLE_FRAMES(3),
    .DRAIN_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .req_freq_flag(req_freq_flag),
    .req_bypass   (req_bypass),
    .freq_flag    (freq_flag),
    .bypass       (bypass),
    .frame_active (frame_active),
    .pixel_count  (pixel_count),
    .frame_count  (frame_count),
    .err_len      (err_len),
    .err_sop      (err_sop),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    bus.in_valid  = 1'b0;
    bus.in_ready  = 1'b0;
    bus.in_sop    = 1'b0;
    bus.in_eop    = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.out_sop   = 1'b0;
    bus.out_eop   = 1'b0;
  endtask

  task automatic drive_beat(input logic s, input logic e);
    bus.in_valid = 1'b1;
    bus.in_ready = 1'b1;
    bus.in_sop   = s;
    bus.in_eop   = e;
    step();
    clear_bus();
  endtask

  task automatic send_frame(input int n);
    for (int i = 1; i <= n; i++)
      drive_beat(i == 1, i == n);
  endtask

  task automatic out_eop_beat();
    bus.out_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.out_sop   = 1'b0;
    bus.out_eop   = 1'b1;
    step();
    clear_bus();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int beats;
    int cyc;
    clear_bus();

    // Reset state
    do_reset();
    check("rst_freq", freq_flag, 0);
    check("rst_bypass", bypass, 0);
    check("rst_active", frame_active, 0);
    check("rst_pixels", pixel_count, 0);
    check("rst_frames", frame_count, 0);
    check("rst_errs", {err_len, err_sop, err_timeout}, 0);

    // Three good frames with req_freq_flag=1
    req_freq_flag = 1'b1;
    send_frame(63);
    check("f1_pixels", pixel_count, 63);
    check("f1_err_len", err_len, 0);
    check("f1_active", frame_active, 1);
    out_eop_beat();
    check("f1_frames", frame_count, 1);
    check("f1_freq", freq_flag, 0);
    check("f1_active_done", frame_active, 0);
    send_frame(63);
    out_eop_beat();
    check("f2_frames", frame_count, 2);
    check("f2_freq", freq_flag, 0);
    send_frame(63);
    check("f3_freq_pre", freq_flag, 0);
    check("f3_err_len", err_len, 0);
    out_eop_beat();
    check("f3_frames", frame_count, 3);
    check("f3_freq", freq_flag, 1);
    check("f3_errs", {err_len, err_sop, err_timeout}, 0);

    // Toggling request never settles
    do_reset();
    for (int f = 0; f < 5; f++) begin
      req_freq_flag = (f % 2 == 0);
      send_frame(63);
      out_eop_beat();
      check("tog_freq", freq_flag, 0);
    end
    check("tog_frames", frame_count, 5);

    // Short frame: EOP on beat 60
    do_reset();
    req_freq_flag = 1'b0;
    send_frame(60);
    check("short_err_len", err_len, 1);
    check("short_pixels", pixel_count, 60);
    check("short_active", frame_active, 1);
    step();
    check("short_err_len_once", err_len, 0);
    out_eop_beat();
    check("short_frames", frame_count, 1);
    check("short_pixels_hold", pixel_count, 60);

    // Resync SOP on beat 30
    drive_beat(1'b1, 1'b0);
    for (int i = 2; i <= 29; i++)
      drive_beat(1'b0, 1'b0);
    drive_beat(1'b1, 1'b0);
    check("resync_err_sop", err_sop, 1);
    check("resync_pixels", pixel_count, 1);
    drive_beat(1'b0, 1'b0);
    check("resync_err_sop_once", err_sop, 0);
    check("resync_pixels2", pixel_count, 2);
    for (int i = 3; i <= 62; i++)
      drive_beat(1'b0, 1'b0);
    drive_beat(1'b0, 1'b1);
    check("resync_err_len", err_len, 0);
    check("resync_final", pixel_count, 63);

    // Drain timeout: no output EOP, config still applied
    req_bypass = 1'b1;
    for (int i = 1; i <= 15; i++)
      step();
    check("to_pre_pulse", err_timeout, 0);
    check("to_pre_active", frame_active, 1);
    check("to_pre_bypass", bypass, 0);
    step();
    check("to_pulse", err_timeout, 1);
    check("to_active", frame_active, 0);
    check("to_frames", frame_count, 1);
    check("to_bypass", bypass, 1);
    step();
    check("to_pulse_once", err_timeout, 0);

    // Bypass request mid-frame with alternating input ready
    req_bypass = 1'b0;
    do_reset();
    beats = 0;
    cyc = 0;
    while (beats < 63 && cyc < 400) begin
      bus.in_valid = 1'b1;
      bus.in_ready = (cyc % 2 == 1);
      bus.in_sop   = (beats == 0);
      bus.in_eop   = (beats == 62);
      if (beats == 30) req_bypass = 1'b1;
      step();
      if (bus.in_ready) beats++;
      cyc++;
    end
    clear_bus();
    check("byp_beats_done", beats, 63);
    check("byp_pixels", pixel_count, 63);
    check("byp_err_len", err_len, 0);
    check("byp_hold_frame", bypass, 0);
    bus.out_valid = 1'b1;
    bus.out_ready = 1'b0;
    bus.out_eop   = 1'b1;
    step();
    check("byp_hold_stall", bypass, 0);
    check("byp_active_stall", frame_active, 1);
    out_eop_beat();
    check("byp_applied", bypass, 1);
    check("byp_frames", frame_count, 1);

    // Reset mid-frame
    send_frame(10);
    check("mid_pixels", pixel_count, 10);
    bus.in_valid = 1'b1;
    bus.in_ready = 1'b1;
    reset_n = 1'b0;
    step();
    check("mid_rst_bypass", bypass, 0);
    check("mid_rst_freq", freq_flag, 0);
    check("mid_rst_pixels", pixel_count, 0);
    check("mid_rst_frames", frame_count, 0);
    check("mid_rst_active", frame_active, 0);
    check("mid_rst_errs", {err_len, err_sop, err_timeout}, 0);
    reset_n = 1'b1;
    step();
    step();
    check("mid_no_sop_ignored", pixel_count, 0);
    check("mid_no_sop_idle", frame_active, 0);
    clear_bus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blur_frame_sequencer.md
Name: blur_frame_sequencer

Overview:
- Frame-level controller for the blurring filter's streaming datapath.
- Snoops the filter's input and output ready/valid/startofpacket/endofpacket interfaces and tracks frame boundaries.
- Applies kernel-size (freq_flag) and bypass changes only between frames. A freq_flag change is applied only after the request has been stable for a set number of frames.
- Counts pixels and frames, and flags malformed frames and drain stalls. It sits between the audio/control logic and the blurring filter's freq_flag input.

Parameters:
- IMAGE_WIDTH, 320: pixels per line.
- IMAGE_HEIGHT, 240: lines per frame; IMAGE_WIDTH*IMAGE_HEIGHT must be at least 2.
- STABLE_FRAMES, 3: consecutive frames req_freq_flag must hold before it is applied; minimum 1.
- DRAIN_TIMEOUT, 4096: maximum cycles from input EOP to output EOP.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req_freq_flag  in  1  requested kernel size, asynchronous to frames
- req_bypass  in  1  requested filter bypass
- in_valid  in  1  filter input valid
- in_ready  in  1  filter input ready (the filter's ready_out)
- in_sop  in  1  filter input startofpacket
- in_eop  in  1  filter input endofpacket
- out_valid  in  1  filter output valid
- out_ready  in  1  downstream ready (the filter's ready_in)
- out_sop  in  1  filter output startofpacket
- out_eop  in  1  filter output endofpacket
- freq_flag  out  1  applied kernel size, to the filter
- bypass  out  1  applied bypass select
- frame_active  out  1  high in states IN_FRAME and DRAIN
- pixel_count  out  32  input beats accepted in the current frame
- frame_count  out  16  completed frames, wraps modulo 2^16
- err_len  out  1  one-cycle pulse: input EOP arrived with pixel count not equal to W*H
- err_sop  out  1  one-cycle pulse: input SOP arrived mid-frame
- err_timeout  out  1  one-cycle pulse: drain exceeded DRAIN_TIMEOUT

Behaviour:
- Beat definitions:
  - Input beat: in_valid && in_ready.
  - Output beat: out_valid && out_ready.
  - sop/eop are qualified only on beats.
- Reset (synchronous, on the clk edge while reset_n=0):
  - state=WAIT_SOP.
  - freq_flag=0, bypass=0.
  - pixel_count=0, frame_count=0.
  - All err_* outputs=0; debounce candidate=0, stable count=0; drain timer=0.
  - Reset asserted mid-frame abandons the frame without raising any error.
- Registered outputs: all outputs are registered; each updates on the same edge as the causing beat.
- State WAIT_SOP:
  - Input beats without sop are ignored and not counted.
  - An input beat with sop sets pixel_count=1 and moves to IN_FRAME.
- State IN_FRAME:
  - Each input beat increments pixel_count.
  - A beat with sop and without eop pulses err_sop, sets pixel_count=1, and stays in IN_FRAME (resync).
  - A beat with eop uses the final count, including that beat:
    - err_len pulses if the final count differs from W*H.
    - Debounce update: if req_freq_flag equals the candidate, stable count increments, saturating at STABLE_FRAMES. Otherwise candidate=req_freq_flag and stable count=1.
    - Moves to DRAIN with drain timer=0.
  - A beat with both sop and eop is treated as eop only.
- State DRAIN:
  - The drain timer increments every cycle.
  - An output beat with out_eop commits the frame and moves to WAIT_SOP.
  - If the drain timer reaches DRAIN_TIMEOUT first, err_timeout pulses and the state moves to WAIT_SOP. frame_count is not incremented and config is still applied.
  - An input sop beat in DRAIN is ignored.
- Frame commit (on DRAIN exit):
  - frame_count increments.
  - bypass takes req_bypass.
  - freq_flag takes the candidate if stable count is at least STABLE_FRAMES.
  - pixel_count holds its value until the next SOP.
- Config stability: freq_flag and bypass never change while frame_active=1.
- Output-side monitoring: output sop is not checked.

Decomposition:
- Shared package blur_pkg holds:
  - the state enum (WAIT_SOP, IN_FRAME, DRAIN);
  - the 12-bit pixel typedef;
  - the PIXEL_COUNT_W=32 constant.
- One natural sub-module is blur_flag_debouncer, which holds the candidate, the stable count and the apply decision.

Test Plan:
- Reset, then three 9x7 frames (63 beats each) with req_freq_flag=1 and STABLE_FRAMES=3 -> freq_flag=1 only after the third output EOP; frame_count=3; no errors.
- req_freq_flag toggles every frame for 5 frames -> freq_flag stays 0.
- Frame with EOP on beat 60 (W=9, H=7) -> err_len pulses once; state goes to DRAIN; pixel_count=60.
- SOP on beat 30 of a frame -> err_sop pulses; pixel_count=1 on that cycle; an EOP 63 beats later gives no err_len.
- Input EOP then no out_eop for DRAIN_TIMEOUT=16 cycles -> err_timeout pulses at cycle 16; state is WAIT_SOP; frame_count unchanged.
- req_bypass=1 mid-frame with alternating ready -> bypass stays 0 until output EOP, then 1; reset_n=0 mid-frame -> all outputs at reset values on the next edge.
